glitch_filter: RTL and testbench
================================

Name: glitch_filter

Overview:
- Multi-channel input synchronizer and glitch filter for the hazard-prone combinational outputs the team characterises in glitch simulation.
- Each channel passes a level change only after it has been stable for STABLE_CYCLES clocks. Shorter pulses are rejected, flagged and counted.
- Sits between asynchronous or combinational sources and downstream synchronous logic.

Parameters:
N, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchronizer flops per channel (>=2)
STABLE_CYCLES, 4, consecutive stable cycles required to accept a change (>=1)
CNT_W, 8, width of saturating global glitch counter
INIT, 0, reset value of sync flops and filtered outputs (1 bit, all channels)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous active-high reset
din  input  N  raw asynchronous/combinational inputs
clr  input  1  clears glitch_flag and glitch_cnt
dout  output  N  filtered, synchronised levels
rise  output  N  one-cycle pulse when dout[i] goes 0->1
fall  output  N  one-cycle pulse when dout[i] goes 1->0
glitch_flag  output  N  sticky, set on a rejected pulse
glitch_cnt  output  CNT_W  total rejected pulses across all channels, saturating

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset: every sync flop and dout = {N{INIT}}; rise = fall = 0; glitch_flag = 0; glitch_cnt = 0; per-channel counters = 0.
- Reset mid-operation aborts any partial count. No pulse or flag is generated by the reset itself.
- Per channel i, let s = last sync stage and q = dout[i]. Each edge, with priority in this order:
  - s == q: cnt <= 0. If cnt != 0, this is a glitch event: set glitch_flag[i] and add to the global count.
  - s != q and cnt == STABLE_CYCLES-1: q <= s; cnt <= 0; rise[i] or fall[i] = 1 for exactly one cycle, matching the new level.
  - s != q otherwise: cnt <= cnt + 1.
- cnt width is clog2(STABLE_CYCLES) (minimum 1).
- Latency: with din[i] changed before edge 0 and held, dout[i] changes at edge SYNC_STAGES+STABLE_CYCLES-1. Defaults: edge 5.
- Pulse acceptance, in synchronised cycles: shorter than STABLE_CYCLES is rejected; exactly STABLE_CYCLES passes.
- A change that reverses mid-count counts as one glitch, flagged when s returns to q.
- Opposite change during count: impossible by construction, since s is binary relative to q.
- Global counter: glitch_cnt <= sat(glitch_cnt + popcount(events this cycle)).
  - Saturates at 2^CNT_W-1 and never wraps.
  - Simultaneous events on several channels all count.
- clr, when reset is low:
  - glitch_flag <= events this cycle (set has priority over clear for same-cycle events).
  - glitch_cnt <= popcount(events this cycle).
  - dout, rise, fall and the filters are unaffected.
- reset has priority over clr.
- All outputs are registered. No combinational path from din to any output.

Decomposition:
- Package glitch_filter_pkg:
  - default parameter constants;
  - a popcount function over N bits;
  - a sat_add function (CNT_W) for the saturating counter.
- Sub-module glitch_filter_ch, generated N times:
  - contains the synchronizer, stable counter, q, rise/fall and a glitch-event output.
- Top glitch_filter:
  - owns the sticky flags, clr handling and the global saturating counter.

Test Plan:
All cases use defaults (N=4, SYNC_STAGES=2, STABLE_CYCLES=4, CNT_W=8).
1. Hold reset 2 cycles with din=4'hF -> dout=0, rise=fall=0, glitch_flag=0, glitch_cnt=0 during and immediately after reset.
2. din[0] 0->1 before edge 0, held -> dout[0]=1 from edge 5; rise[0]=1 for that single cycle; glitch_cnt stays 0. Release -> fall[0] pulses 5 edges later.
3. din[1] pulses high for 1, 2 and 3 cycles, separated by 10 idle cycles -> dout[1] never changes; glitch_flag[1]=1; glitch_cnt=3.
4. din[2] pulses for exactly 4 cycles -> dout[2] high for exactly 4 cycles; rise[2] and fall[2] each pulse once; no glitch counted.
5. din[3:1] glitch (2 cycles) in the same cycle -> glitch_cnt increments by 3 in one edge. 90 such triple events -> glitch_cnt saturates at 255 and does not wrap.
6. Ordering checks:
  - clr asserted in the same cycle as a glitch event on ch1 -> next cycle glitch_flag=4'b0010, glitch_cnt=1.
  - reset asserted with cnt=2 on ch0 -> no later change or pulse on dout[0].

Source files
------------

// File: rtl/glitch_filter_pkg.sv
// Shared constants and helpers for the multi-channel glitch filter.
// Holds the default parameters, a popcount and a saturating adder used by the global counter.
package glitch_filter_pkg;

    localparam int unsigned N_DEF             = 4;
    localparam int unsigned SYNC_STAGES_DEF   = 2;
    localparam int unsigned STABLE_CYCLES_DEF = 4;
    localparam int unsigned CNT_W_DEF         = 8;
    localparam logic        INIT_DEF          = 1'b0;

    // Wide enough for any realistic channel count; callers zero-extend.
    localparam int unsigned POP_MAX_W = 64;

    function automatic logic [31:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [31:0] c;
        c = 32'd0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            c = c + {31'd0, v[i]};
        end
        return c;
    endfunction

    // Adds b to a, clamping at 2^w-1 (w <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum_v;
        logic [32:0] max_v;
        sum_v = {1'b0, a} + {1'b0, b};
        max_v = (33'd1 << w) - 33'd1;
        if (sum_v > max_v) begin
            return max_v[31:0];
        end else begin
            return sum_v[31:0];
        end
    endfunction

endpackage

// File: rtl/glitch_filter_ch.sv
// One filter channel: synchronizer, stability counter, filtered level and edge pulses.
// glitch_evt is high in the cycle a partial count is abandoned because the input returned.
module glitch_filter_ch
    import glitch_filter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter logic        INIT          = INIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic glitch_evt
);

    localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cnt_r;
    logic                   q_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   s_s;

    assign s_s        = sync_r[SYNC_STAGES-1];
    assign dout       = q_r;
    assign rise       = rise_r;
    assign fall       = fall_r;
    assign glitch_evt = (s_s == q_r) && (cnt_r != {CW{1'b0}});

    // Synchronizer shift, stability counting and acceptance of a new level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{INIT}};
            q_r    <= INIT;
            cnt_r  <= {CW{1'b0}};
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            if (s_s == q_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r == CNT_MAX) begin
                q_r    <= s_s;
                cnt_r  <= {CW{1'b0}};
                rise_r <= s_s;
                fall_r <= ~s_s;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/glitch_filter.sv
// Multi-channel glitch filter top: per-channel filters plus sticky glitch flags
// and a saturating global count of rejected pulses.
module glitch_filter
    import glitch_filter_pkg::*;
#(
    parameter int unsigned N             = N_DEF,
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF,
    parameter logic        INIT          = INIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     din,
    input  logic             clr,
    output logic [N-1:0]     dout,
    output logic [N-1:0]     rise,
    output logic [N-1:0]     fall,
    output logic [N-1:0]     glitch_flag,
    output logic [CNT_W-1:0] glitch_cnt
);

    logic [N-1:0]     evt_s;
    logic [N-1:0]     flag_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [31:0]      pop_s;

    for (genvar i = 0; i < N; i++) begin : g_ch
        glitch_filter_ch #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .INIT         (INIT)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .din       (din[i]),
            .dout      (dout[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .glitch_evt(evt_s[i])
        );
    end

    assign glitch_flag = flag_r;
    assign glitch_cnt  = cnt_r;

    // Next global count: restart from this cycle's events on clr, else accumulate.
    always_comb begin
        pop_s = popcount(POP_MAX_W'(evt_s));
        if (clr) begin
            cnt_nxt_s = CNT_W'(sat_add(32'd0, pop_s, CNT_W));
        end else begin
            cnt_nxt_s = CNT_W'(sat_add(32'(cnt_r), pop_s, CNT_W));
        end
    end

    // Sticky flags and counter; same-cycle events survive a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_r <= {N{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else if (clr) begin
            flag_r <= evt_s;
            cnt_r  <= cnt_nxt_s;
        end else begin
            flag_r <= flag_r | evt_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_glitch_filter.sv
// Directed bench for glitch_filter with default parameters: a vector table for
// reset/latency/exact-length pulses, plus hand sequences for glitches, saturation and ordering.
module tb_glitch_filter;

    logic       clk;
    logic       reset;
    logic [3:0] din;
    logic       clr;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] glitch_flag;
    logic [7:0] glitch_cnt;

    int n_vec;
    int n_bad;

    typedef struct {
        logic [3:0] din;
        logic       clr;
        logic       rst;
        logic [3:0] dout;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] flag;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    glitch_filter dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .clr        (clr),
        .dout       (dout),
        .rise       (rise),
        .fall       (fall),
        .glitch_flag(glitch_flag),
        .glitch_cnt (glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic [3:0] d, input logic c, input logic r,
                                input logic [3:0] eo, input logic [3:0] er,
                                input logic [3:0] ef, input logic [3:0] eg,
                                input logic [7:0] ec);
        vec_t v;
        v.din = d; v.clr = c; v.rst = r;
        v.dout = eo; v.rise = er; v.fall = ef; v.flag = eg; v.cnt = ec;
        tbl.push_back(v);
    endfunction

    task automatic step(input logic [3:0] d, input logic c, input logic r);
        din   = d;
        clr   = c;
        reset = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_cnt;
        din   = 4'h0;
        clr   = 1'b0;
        reset = 1'b1;
        n_vec = 0;
        n_bad = 0;

        // Reset with din all high.
        add(4'hF, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);
        add(4'hF, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);
        add(4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);
        // ch0 held high: accepted 5 edges after first sample, then released.
        for (int i = 0; i < 5; i++) add(4'h1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);
        add(4'h1, 1'b0, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 8'd0);
        add(4'h1, 1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 8'd0);
        for (int i = 0; i < 5; i++) add(4'h0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 8'd0);
        add(4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h1, 4'h0, 8'd0);
        add(4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);
        // ch2 pulse of exactly STABLE_CYCLES: passes, high for 4 cycles.
        for (int i = 0; i < 4; i++) add(4'h4, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);
        add(4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);
        add(4'h0, 1'b0, 1'b0, 4'h4, 4'h4, 4'h0, 4'h0, 8'd0);
        for (int i = 0; i < 3; i++) add(4'h0, 1'b0, 1'b0, 4'h4, 4'h0, 4'h0, 4'h0, 8'd0);
        add(4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h4, 4'h0, 8'd0);
        add(4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0);

        foreach (tbl[k]) begin
            step(tbl[k].din, tbl[k].clr, tbl[k].rst);
            n_vec++;
            if ({dout, rise, fall, glitch_flag, glitch_cnt} !==
                {tbl[k].dout, tbl[k].rise, tbl[k].fall, tbl[k].flag, tbl[k].cnt}) begin
                n_bad++;
                $display("FAIL table[%0d]: got dout=%h rise=%h fall=%h flag=%h cnt=%0d expected dout=%h rise=%h fall=%h flag=%h cnt=%0d",
                         k, dout, rise, fall, glitch_flag, glitch_cnt,
                         tbl[k].dout, tbl[k].rise, tbl[k].fall, tbl[k].flag, tbl[k].cnt);
            end
        end

        // ch1 pulses of 1, 2 and 3 cycles are all rejected.
        for (int w = 1; w <= 3; w++) begin
            for (int i = 0; i < w; i++) begin
                step(4'h2, 1'b0, 1'b0);
                chk("short_pulse_dout", 32'(dout), 32'h0);
            end
            for (int i = 0; i < 10; i++) begin
                step(4'h0, 1'b0, 1'b0);
                chk("short_pulse_dout", 32'(dout), 32'h0);
            end
            chk("short_pulse_cnt", 32'(glitch_cnt), 32'(w));
        end
        chk("short_pulse_flag", 32'(glitch_flag), 32'h2);

        // Triple simultaneous glitches on ch3..ch1, running into saturation.
        step(4'h0, 1'b1, 1'b0);
        chk("clr_idle_cnt", 32'(glitch_cnt), 32'h0);
        chk("clr_idle_flag", 32'(glitch_flag), 32'h0);
        exp_cnt = 8'd0;
        for (int g = 0; g < 90; g++) begin
            step(4'hE, 1'b0, 1'b0);
            step(4'hE, 1'b0, 1'b0);
            step(4'h0, 1'b0, 1'b0);
            step(4'h0, 1'b0, 1'b0);
            chk("triple_before", 32'(glitch_cnt), 32'(exp_cnt));
            step(4'h0, 1'b0, 1'b0);
            exp_cnt = (exp_cnt > 8'd252) ? 8'd255 : exp_cnt + 8'd3;
            chk("triple_after", 32'(glitch_cnt), 32'(exp_cnt));
            step(4'h0, 1'b0, 1'b0);
            step(4'h0, 1'b0, 1'b0);
        end
        chk("sat_cnt", 32'(glitch_cnt), 32'd255);
        chk("sat_flag", 32'(glitch_flag), 32'hE);
        chk("sat_dout", 32'(dout), 32'h0);

        // clr coincides with a glitch event on ch1: set wins.
        step(4'h2, 1'b0, 1'b0);
        step(4'h2, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0);
        step(4'h0, 1'b1, 1'b0);
        chk("clr_evt_flag", 32'(glitch_flag), 32'h2);
        chk("clr_evt_cnt", 32'(glitch_cnt), 32'd1);
        step(4'h0, 1'b0, 1'b0);
        chk("clr_evt_hold", {20'd0, glitch_flag, glitch_cnt}, {20'd0, 4'h2, 8'd1});

        // Reset lands while ch0 has counted to 2: nothing may follow.
        for (int i = 0; i < 4; i++) step(4'h1, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b1);
        chk("rst_mid_state", {12'd0, dout, rise, fall, glitch_flag, glitch_cnt}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(4'h0, 1'b0, 1'b0);
            chk("rst_mid_after", {12'd0, dout, rise, fall, glitch_flag, glitch_cnt}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
